// File: rtl/uart_rx_bank.sv
// uart_rx_bank: 8N1 UART receiver feeding a 2**FIFO_AW-deep receive FIFO, read and popped over the MCS IO bank.
// Build with UART_RX_PARITY_EN defined for 8E1 frames with even-parity checking (STATUS[4] = PERR).
module uart_rx_bank #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  input  logic [31:0] IO_Address,
  input  logic [31:0] IO_Write_Data,
  input  logic        WR,
  output logic [31:0] RDATA,
  output logic        RX_IRQ
);
  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(DIV + 1);
  localparam logic [BW-1:0]    FULL_BIT = BW'(DIV - 1);
  localparam logic [BW-1:0]    HALF_BIT = BW'(DIV / 2 - 1);
  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic               rx_meta_q, rxs_q;
  state_t             state_q, state_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [2:0]         bidx_q, bidx_d;
  logic [7:0]         shift_q, shift_d;
  logic               push_req, ferr_set;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
  logic               perr;
  logic [1:0]         reg_sel;
  logic               pop_req, clr_req, full, empty, pop_ok, push_ok, ovr_set;
  logic [7:0]         head;
  logic               unused_ok;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d, perr_q, perr_d, perr_set;
`endif

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_set = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          bcnt_d  = HALF_BIT;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BW'(1);
        end else if (!rxs_q) begin
          state_d = S_DATA;
          bcnt_d  = FULL_BIT;
          bidx_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BW'(1);
        end else begin
          shift_d[bidx_q] = rxs_q;
          bcnt_d = FULL_BIT;
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BW'(1);
        end else begin
          par_d   = rxs_q;
          bcnt_d  = FULL_BIT;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BW'(1);
        end else begin
          // Back to IDLE immediately so a start bit right after the stop sample is caught.
          state_d  = S_IDLE;
          ferr_set = !rxs_q;
`ifdef UART_RX_PARITY_EN
          perr_set = ^{shift_q, par_q};
          push_req = rxs_q && !perr_set;
`else
          push_req = rxs_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_sel = IO_Address[3:2];
  assign pop_req = WR && (reg_sel == 2'd0);
  assign clr_req = WR && (reg_sel == 2'd1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign pop_ok  = pop_req && !empty;
  // A pop landing with the push frees the slot, so a full FIFO still accepts the byte.
  assign push_ok = push_req && (!full || pop_ok);
  assign ovr_set = push_req && full && !pop_ok;
  assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push_ok);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop_ok);
    count_d  = count_q + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop_ok);
    ovr_d    = (ovr_q && !(clr_req && IO_Write_Data[0])) || ovr_set;
    ferr_d   = (ferr_q && !(clr_req && IO_Write_Data[1])) || ferr_set;
    irq_d    = !empty;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      bidx_q    <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rx_meta_q <= RXD;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      bidx_q    <= bidx_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

`ifdef UART_RX_PARITY_EN
  always_comb perr_d = (perr_q && !(clr_req && IO_Write_Data[4])) || perr_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    RDATA = '0;
    case (reg_sel)
      2'd0: RDATA = {23'b0, !empty, head};
      2'd1: begin
        RDATA[0]           = ovr_q;
        RDATA[1]           = ferr_q;
        RDATA[2]           = empty;
        RDATA[3]           = full;
        RDATA[4]           = perr;
        RDATA[8+FIFO_AW:8] = count_q;
      end
      2'd2:    RDATA = 32'(DIV);
      default: RDATA = '0;
    endcase
  end

  assign RX_IRQ    = irq_q;
  assign unused_ok = ^{IO_Address[31:4], IO_Address[1:0], IO_Write_Data[31:2]};
endmodule

// File: tb/tb_uart_rx_bank.sv
// Bench for uart_rx_bank: register table, directed frame sequences and random traffic
// checked against a byte-queue model of the receiver and its sticky flags.
module tb_uart_rx_bank;
  localparam int CLK_HZ = 1843200;
  localparam int BAUD   = 115200;
  localparam int DIV    = 16;

  logic        clk = 1'b0;
  logic        rst, rxd, wr, irq;
  logic [31:0] addr, wdata, rdata;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_bank #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_AW(4)) dut (
    .CLK(clk), .RST(rst), .RXD(rxd), .IO_Address(addr), .IO_Write_Data(wdata),
    .WR(wr), .RDATA(rdata), .RX_IRQ(irq)
  );

  int vectors = 0, miscompares = 0;

  // Reference model: the FIFO is a byte queue, flags are plain bits.
  logic [7:0] mq[$];
  bit m_ovr, m_ferr, m_perr;

  function automatic void m_frame(logic [7:0] d, bit stop, bit par_ok);
    if (!stop) m_ferr = 1'b1;
    if (!par_ok) m_perr = 1'b1;
    if (stop && par_ok) begin
      if (mq.size() < 16) mq.push_back(d);
      else m_ovr = 1'b1;
    end
  endfunction

  function automatic void m_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endfunction

  function automatic void m_clear(logic [31:0] wd);
    if (wd[0]) m_ovr = 1'b0;
    if (wd[1]) m_ferr = 1'b0;
    if (wd[4]) m_perr = 1'b0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[0] = m_ovr;
    s[1] = m_ferr;
    s[2] = (mq.size() == 0);
    s[3] = (mq.size() == 16);
    s[4] = m_perr;
    s[12:8] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] m_rxdata();
    if (mq.size() == 0) return 32'h0;
    return {23'b0, 1'b1, mq[0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic bit_wait(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(logic [31:0] a, output logic [31:0] d);
    addr = a;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic bus_wr(logic [31:0] a, logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic check_reg(string name, logic [31:0] a, logic [31:0] exp);
    logic [31:0] r;
    bus_rd(a, r);
    check(name, r, exp);
  endtask

  task automatic check_model(string name);
    check({name, "_status"}, 32'h0, 32'h0 ^ 32'h0 ^ 32'h0) ;
  endtask

  // One frame, bit-aligned to the clock. A bad stop bit is held low for only
  // three quarters of a bit so the idle line is back before the next start check.
  task automatic send_frame(logic [7:0] d, bit stop, bit par_flip);
    @(posedge clk); #1;
    rxd = 1'b0; bit_wait(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i]; bit_wait(DIV);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip; bit_wait(DIV);
`endif
    rxd = stop;
    if (stop) bit_wait(DIV);
    else begin
      bit_wait(DIV * 3 / 4); rxd = 1'b1; bit_wait(DIV / 4);
    end
    bit_wait(DIV);
  endtask

  typedef struct packed {
    logic        do_wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  int          lat = 0, s_cyc = 0;
  bit          seen = 0;
  logic [31:0] r, exp_simul;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rxd = 1'b1; addr = '0; wdata = '0; wr = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("irq_reset", 32'(irq), 32'h0);

    tbl[0] = '{1'b0, 32'h00, 32'h0,         32'h000};
    tbl[1] = '{1'b0, 32'h04, 32'h0,         32'h004};
    tbl[2] = '{1'b0, 32'h08, 32'h0,         32'(DIV)};
    tbl[3] = '{1'b0, 32'h0C, 32'h0,         32'h000};
    tbl[4] = '{1'b1, 32'h08, 32'hFFFF_FFFF, 32'(DIV)};
    tbl[5] = '{1'b1, 32'h00, 32'h0,         32'h000};
    tbl[6] = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h004};
    tbl[7] = '{1'b0, 32'h14, 32'h0,         32'h004};
    tbl[8] = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h000};
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].do_wr) bus_wr(tbl[i].a, tbl[i].wd);
      bus_rd(tbl[i].a, r);
      check($sformatf("tbl[%0d]", i), r, tbl[i].exp);
    end

    // 0x55, while recording how many clocks after the start edge the push lands.
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        s_cyc = cyc; addr = 32'h4;
        for (int k = 0; k < 12 * DIV && !seen; k++) begin
          @(negedge clk);
          if (rdata[12:8] != 5'd0) begin
            seen = 1'b1; lat = cyc - s_cyc;
          end
        end
      end
    join
    check("rx_in_time", 32'(seen), 32'h1);
    m_frame(8'h55, 1'b1, 1'b1);
    check_reg("rx55_data", 32'h0, m_rxdata());
    check("rx55_irq", 32'(irq), 32'h1);
    bus_wr(32'h0, 32'h0); m_pop();
    @(negedge clk);
    check("irq_after_pop_c1", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_after_pop_c2", 32'(irq), 32'h0);
    check_reg("rx55_popped", 32'h0, m_rxdata());
    check_reg("rx55_status", 32'h4, m_status());

    // Overrun: 17 bytes with no pops.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      m_frame(8'(i), 1'b1, 1'b1);
    end
    check_reg("ovr_status", 32'h4, m_status());
    for (int i = 0; i < 16; i++) begin
      check_reg($sformatf("ovr_pop%0d", i), 32'h0, m_rxdata());
      bus_wr(32'h0, 32'h0); m_pop();
    end
    check_reg("ovr_drained", 32'h4, m_status());
    bus_wr(32'h4, 32'h1); m_clear(32'h1);
    check_reg("ovr_cleared", 32'h4, m_status());

    // Framing error.
    send_frame(8'hA5, 1'b0, 1'b0);
    m_frame(8'hA5, 1'b0, 1'b1);
    check_reg("ferr_status", 32'h4, m_status());
    bus_wr(32'h4, 32'h2); m_clear(32'h2);
    check_reg("ferr_cleared", 32'h4, m_status());

    // Short low glitch, then a real frame.
    @(posedge clk); #1;
    rxd = 1'b0; bit_wait(5); rxd = 1'b1; bit_wait(DIV);
    check_reg("glitch_status", 32'h4, m_status());
    send_frame(8'h3C, 1'b1, 1'b0);
    m_frame(8'h3C, 1'b1, 1'b1);
    check_reg("after_glitch", 32'h0, m_rxdata());
    bus_wr(32'h0, 32'h0); m_pop();

    // Full FIFO: pop and stop-bit push of 0x7E on the same clock.
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h40 + 8'(i), 1'b1, 1'b0);
      m_frame(8'h40 + 8'(i), 1'b1, 1'b1);
    end
    check_reg("simul_pre", 32'h4, m_status());
    m_pop(); m_frame(8'h7E, 1'b1, 1'b1);
    exp_simul = m_status();
    fork
      send_frame(8'h7E, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        repeat (lat - 1) begin @(posedge clk); #1; end
        addr = 32'h0; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; addr = 32'h4;
        @(negedge clk);
        check("simul_status", rdata, exp_simul);
      end
    join
    for (int i = 0; i < 16; i++) begin
      check_reg($sformatf("simul_pop%0d", i), 32'h0, m_rxdata());
      bus_wr(32'h0, 32'h0); m_pop();
    end
    check_reg("simul_drained", 32'h4, m_status());

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1);
    m_frame(8'h01, 1'b1, 1'b0);
    check_reg("perr_status", 32'h4, m_status());
    bus_wr(32'h4, 32'h10); m_clear(32'h10);
    send_frame(8'h01, 1'b1, 1'b0);
    m_frame(8'h01, 1'b1, 1'b1);
    check_reg("par_ok_data", 32'h0, m_rxdata());
    bus_wr(32'h0, 32'h0); m_pop();
`endif

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [7:0] d;
      bit stop, flip;
      logic [31:0] wd;
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        d = 8'($urandom);
        stop = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
        flip = ($urandom_range(0, 5) == 0);
`else
        flip = 1'b0;
`endif
        send_frame(d, stop, flip);
        m_frame(d, stop, !flip);
      end else if (op == 2) begin
        bus_wr(32'h0, 32'h0); m_pop();
      end else begin
        wd = $urandom;
        bus_wr(32'h4, wd); m_clear(wd);
      end
      check_reg($sformatf("rnd%0d_status", n), 32'h4, m_status());
      check_reg($sformatf("rnd%0d_data", n), 32'h0, m_rxdata());
      check($sformatf("rnd%0d_irq", n), 32'(irq), 32'(mq.size() != 0));
    end

    // Reset mid-frame: the 0xFF frame must be abandoned.
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        bit_wait(4 * DIV); rst = 1'b1; bit_wait(2); rst = 1'b0;
      end
    join
    mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    check_reg("rst_mid_status", 32'h4, m_status());
    check_reg("rst_mid_data", 32'h0, m_rxdata());
    check("rst_mid_irq", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
